// File: rtl/score_history.sv
// Per-mode sliding-window run statistics: best and floor average of the last DEPTH results per channel.
// Latency: count/best two cycles after commit, avg and done at 2+CH*SW cycles after the commit edge.
// Backpressure: busy while an update runs; commit/clear arriving then are dropped with a drop pulse.
module score_history #(
    parameter int W     = 10,
    parameter int CH    = 2,
    parameter int DEPTH = 8,
    parameter int MODES = 2,
    localparam int MW   = (MODES > 1) ? $clog2(MODES) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit,
    input  logic              clear,
    input  logic [MW-1:0]     mode_in,
    input  logic [CH*W-1:0]   sample,
    input  logic [MW-1:0]     rd_mode,
    output logic [CH*W-1:0]   best,
    output logic [CH*W-1:0]   avg,
    output logic [CW-1:0]     count,
    output logic              busy,
    output logic              done,
    output logic              drop
);

    localparam int SW  = W + CW;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW  = $clog2(SW + 1);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UPD  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Per-mode history and statistics
    logic [W-1:0]  buf_q  [MODES][DEPTH][CH];
    logic [PW-1:0] ptr_q  [MODES];
    logic [CW-1:0] cnt_q  [MODES];
    logic [SW-1:0] sum_q  [MODES][CH];
    logic [W-1:0]  best_q [MODES][CH];
    logic [W-1:0]  avg_q  [MODES][CH];

    // Update / divider working state
    logic [1:0]     state_q;
    logic [MW-1:0]  lm_q;
    logic [CH*W-1:0] ls_q;
    logic [CW-1:0]  div_q;
    logic [SW-1:0]  quo_q;
    logic [SW-1:0]  rem_q;
    logic [BW-1:0]  bit_q;
    logic [CHW-1:0] ch_q;
    logic [W-1:0]   qres_q [CH];
    logic           drop_q;

    // Combinational results for the UPD cycle and one divider step
    logic [CW-1:0]  cur_cnt;
    logic [PW-1:0]  cur_ptr;
    logic           full;
    logic [CW-1:0]  new_cnt;
    logic [SW-1:0]  new_sum  [CH];
    logic [W-1:0]   new_best [CH];
    logic [SW:0]    shifted;
    logic [SW:0]    diff;
    logic           ge;
    logic [SW-1:0]  rem_nx;
    logic [SW-1:0]  quo_nx;
    logic [CHW-1:0] ch_nx;

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign drop = drop_q;

    // Window update for the latched mode: evict-on-full sums, new count, max over the post-write window
    always_comb begin
        logic [W-1:0] v;
        cur_cnt = cnt_q[lm_q];
        cur_ptr = ptr_q[lm_q];
        full    = (cur_cnt == CW'(DEPTH));
        new_cnt = full ? cur_cnt : cur_cnt + 1'b1;
        v       = '0;
        for (int c = 0; c < CH; c++) begin
            new_sum[c] = sum_q[lm_q][c]
                       - (full ? SW'(buf_q[lm_q][cur_ptr][c]) : '0)
                       + SW'(ls_q[c*W +: W]);
            new_best[c] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                v = (PW'(i) == cur_ptr) ? ls_q[c*W +: W] : buf_q[lm_q][i][c];
                if ((CW'(i) < new_cnt) && (v > new_best[c])) begin
                    new_best[c] = v;
                end
            end
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted = {rem_q, quo_q[SW-1]};
        diff    = shifted - {{(SW+1-CW){1'b0}}, div_q};
        ge      = (shifted >= {{(SW+1-CW){1'b0}}, div_q});
        rem_nx  = ge ? diff[SW-1:0] : shifted[SW-1:0];
        quo_nx  = {quo_q[SW-2:0], ge};
        ch_nx   = ch_q + 1'b1;
    end

    // FSM, per-mode state, and divider sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lm_q    <= '0;
            ls_q    <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            bit_q   <= '0;
            ch_q    <= '0;
            drop_q  <= 1'b0;
            for (int c = 0; c < CH; c++) qres_q[c] <= '0;
            for (int m = 0; m < MODES; m++) begin
                ptr_q[m] <= '0;
                cnt_q[m] <= '0;
                for (int c = 0; c < CH; c++) begin
                    sum_q[m][c]  <= '0;
                    best_q[m][c] <= '0;
                    avg_q[m][c]  <= '0;
                    for (int i = 0; i < DEPTH; i++) buf_q[m][i][c] <= '0;
                end
            end
        end else begin
            // Reject anything arriving mid-update; a commit colliding with a clear loses
            drop_q <= busy ? (commit | clear) : (commit & clear);
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        ptr_q[mode_in] <= '0;
                        cnt_q[mode_in] <= '0;
                        for (int c = 0; c < CH; c++) begin
                            sum_q[mode_in][c]  <= '0;
                            best_q[mode_in][c] <= '0;
                            avg_q[mode_in][c]  <= '0;
                        end
                    end else if (commit) begin
                        lm_q    <= mode_in;
                        ls_q    <= sample;
                        state_q <= ST_UPD;
                    end
                end
                ST_UPD: begin
                    for (int c = 0; c < CH; c++) begin
                        buf_q[lm_q][cur_ptr][c] <= ls_q[c*W +: W];
                        sum_q[lm_q][c]          <= new_sum[c];
                        best_q[lm_q][c]         <= new_best[c];
                    end
                    ptr_q[lm_q] <= (cur_ptr == PW'(DEPTH - 1)) ? '0 : cur_ptr + 1'b1;
                    cnt_q[lm_q] <= new_cnt;
                    // Channel 0 dividend comes straight from the fresh sum
                    div_q   <= new_cnt;
                    quo_q   <= new_sum[0];
                    rem_q   <= '0;
                    bit_q   <= '0;
                    ch_q    <= '0;
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (bit_q == BW'(SW - 1)) begin
                        qres_q[ch_q] <= quo_nx[W-1:0];
                        if (ch_q == CHW'(CH - 1)) begin
                            // Publish all quotients so avg is already new in the DONE cycle
                            for (int c = 0; c < CH; c++) begin
                                avg_q[lm_q][c] <= (CHW'(c) == ch_q) ? quo_nx[W-1:0] : qres_q[c];
                            end
                            state_q <= ST_DONE;
                        end else begin
                            ch_q  <= ch_nx;
                            quo_q <= sum_q[lm_q][ch_nx];
                            rem_q <= '0;
                            bit_q <= '0;
                        end
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output view of the selected mode; follows rd_mode combinationally
    always_comb begin
        best  = '0;
        avg   = '0;
        count = '0;
        if (int'(rd_mode) < MODES) begin
            count = cnt_q[rd_mode];
            for (int c = 0; c < CH; c++) begin
                best[c*W +: W] = best_q[rd_mode][c];
                avg[c*W +: W]  = avg_q[rd_mode][c];
            end
        end
    end

endmodule

// File: doc/score_history.md
# score_history

Parametrised per-mode run-statistics tracker for the TypeRacer result path: it stores the last DEPTH results of each of CH metrics (default WPM and accuracy) per game mode and maintains a best value and a rolling floor average for each. It sits after the result calculator and feeds the statistics display. It adds over the single-mode tracker: multiple modes, a sliding window instead of a lifetime average, a sequential divider, a commit/busy handshake and per-mode clear.

## Interface
- W, 10: metric width in bits (unsigned).
- CH, 2: number of metric channels; channel 0 = WPM, channel 1 = accuracy.
- DEPTH, 8: history window per mode, ≥1; any value, not only powers of 2.
- MODES, 2: number of game modes, ≥1; MW = max(1,$clog2(MODES)).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- commit  in  1  one-cycle pulse: sample holds a finished run's result.
- clear  in  1  one-cycle pulse: erase the history of mode_in.
- mode_in  in  MW  mode targeted by commit/clear.
- sample  in  CH*W  packed metrics; channel c at [c*W +: W].
- rd_mode  in  MW  mode whose statistics drive the outputs.
- best  out  CH*W  per-channel maximum over the window of rd_mode.
- avg  out  CH*W  per-channel floor(sum/count) over the window of rd_mode.
- count  out  $clog2(DEPTH+1)  valid entries for rd_mode, saturates at DEPTH.
- busy  out  1  update in progress; new commit/clear not accepted.
- done  out  1  one-cycle pulse: update finished, new avg visible.
- drop  out  1  one-cycle pulse: commit or clear rejected.

## Operation
- Per mode m: circular buffer DEPTH×CH×W, write pointer, count, per-channel running sum of width SW = W+$clog2(DEPTH+1), best register, avg register.
- FSM: IDLE → UPD → DIV → DONE → IDLE.
- IDLE: commit with busy=0 latches sample and mode_in, then goes to UPD. clear with busy=0 zeroes mode_in's pointer, count, sums, best and avg in one cycle and stays in IDLE.
- UPD (1 cycle):
  - If count==DEPTH, subtract the evicted entry at the pointer from each sum; add the new sample.
  - Write the buffer and advance the pointer, wrapping DEPTH-1→0.
  - count = min(count+1, DEPTH).
- Best is recomputed in UPD as the max over the window after the write, so evicted maxima leave; a combinational max over DEPTH entries is acceptable.
- DIV: restoring divider, one quotient bit per cycle, SW cycles per channel, channels 0..CH-1 in sequence.
- DONE: write all CH quotients into avg of the latched mode, pulse done, return to IDLE.
- Quotient ≤ 2^W−1 by construction; store the low W bits. count==0 cannot occur in DIV.
- Outputs are a mux of registered per-mode state selected by rd_mode; a change of rd_mode is visible in the same cycle.
- Simultaneous commit and clear in IDLE: clear wins; the commit is rejected with drop=1.
- commit or clear while busy=1: ignored, drop=1, no state change.
- Statistics of modes other than the latched/cleared one never change.

## Timing
- Reset values: best=0, avg=0, count=0, busy=0, done=0, drop=0. All buffers, sums and pointers are 0; FSM is IDLE.
- Commit sampled at edge k:
  - busy=1 from cycle k+1 through the DONE cycle.
  - count and best update after edge k+1, i.e. visible from cycle k+2.
  - avg updates and done=1 in cycle k+2+CH*SW; busy falls the next cycle.
  - Defaults: SW=14, so done appears 30 cycles after the commit edge.
- Clear sampled at edge k: zeroed values visible from cycle k+1; busy stays 0.
- drop asserts in the cycle after the rejected pulse.
- rst mid-update: immediate return to reset values; the in-flight result is discarded.

## Test plan
Bench parameters: W=10, CH=2, DEPTH=4, MODES=2.
- Reset, then idle 5 cycles → all outputs 0, busy=0.
- Mode 0 commits (60,90) then (40,100), each after done → best=(60,100), avg=(50,95), count=2; done occurs 2+2*13=28 cycles after each commit edge.
- Mode 0 commits WPM 10,20,30,40,50 with acc 100 → count=4, avg WPM=35, best WPM=50. Then commits 20,20,20,20 → best WPM drops to 20 (eviction).
- Floor rounding: fresh mode 1 commits WPM 10 then 11 → avg=10. rd_mode=0 still shows mode 0 values unchanged.
- Collision cases:
  - commit pulsed at busy=1 → drop=1, and count is unchanged after the pending done.
  - commit+clear in the same IDLE cycle → mode cleared, drop=1, no update starts.
- Assert rst 10 cycles into DIV → all outputs 0 immediately. A following commit (70,80) gives avg=(70,80), count=1.
